// File: rtl/fetch_stage.sv
// Instruction fetch: drives imem reads from pc_in, captures returned words into the IF/ID register,
// parks one word in a skid buffer when decode stalls, handles redirect flushes and stops after HALT.
module fetch_stage #(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc_in,
  output logic        pc_en,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        flush,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      state_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] sk_instr_q;
  logic [31:0] sk_pc_q;
  logic        halt_seen_q;

  logic out_free;
  logic consume;
  logic is_halt;
  logic flush_act;

  assign out_free  = !valid_q || !id_stall;
  assign consume   = valid_q && !id_stall;
  assign is_halt   = (imemload[31:26] == HALT_OP);
  // Once halted the redirect has nowhere to go: the stage stays parked until reset.
  assign flush_act = flush && (state_q != HALTED);

  always_comb begin
    imemREN  = (state_q == FETCH);
    imemaddr = pc_in;
    pc_en    = flush_act || ((state_q == FETCH) && ihit);
  end

  assign if_valid = valid_q;
  assign if_instr = instr_q;
  assign if_pc    = pc_q;
  assign if_npc   = pc_q + 32'd4;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= FETCH;
      valid_q     <= 1'b0;
      instr_q     <= 32'd0;
      pc_q        <= 32'd0;
      sk_instr_q  <= 32'd0;
      sk_pc_q     <= 32'd0;
      halt_seen_q <= 1'b0;
    end else if (flush_act) begin
      state_q     <= FETCH;
      valid_q     <= 1'b0;
      sk_instr_q  <= 32'd0;
      sk_pc_q     <= 32'd0;
      halt_seen_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (ihit && out_free) begin
            valid_q <= 1'b1;
            instr_q <= imemload;
            pc_q    <= pc_in;
            if (is_halt) begin
              halt_seen_q <= 1'b1;
              state_q     <= HALTED;
            end
          end else if (ihit) begin
            sk_instr_q <= imemload;
            sk_pc_q    <= pc_in;
            state_q    <= HOLD;
            if (is_halt) halt_seen_q <= 1'b1;
          end else if (consume) begin
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            valid_q <= 1'b1;
            instr_q <= sk_instr_q;
            pc_q    <= sk_pc_q;
            state_q <= halt_seen_q ? HALTED : FETCH;
          end
        end
        HALTED: begin
          if (consume) valid_q <= 1'b0;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: reset/vector table, HALT and reset corner sequences, randomized scoreboard run.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pc_en;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        flush = 1'b0;
  logic        id_stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_npc;

  int n_chk = 0;
  int n_fail = 0;

  fetch_stage dut (
    .CLK(CLK), .nRST(nRST), .pc_in(pc_in), .pc_en(pc_en), .imemREN(imemREN),
    .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload), .flush(flush),
    .id_stall(id_stall), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_npc(if_npc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    bit          hit;
    logic [31:0] ld;
    bit          st;
    bit          fl;
    bit          e_pcen;
    bit          e_ren;
    bit          e_vld;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  vec_t        tv[17];
  ent_t        q[$];
  logic [31:0] pc_r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input bit hit, input logic [31:0] ld,
                       input bit st, input bit fl);
    @(negedge CLK);
    pc_in = pc; ihit = hit; imemload = ld; id_stall = st; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0; ihit = 1'b0; flush = 1'b0; id_stall = 1'b0; pc_in = '0; imemload = '0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Instruction memory contents: opcode top bit is always 0, so never a HALT.
  function automatic logic [31:0] word(input logic [31:0] p);
    return {1'b0, p[30:0] ^ 31'h2A5A_1C3D};
  endfunction

  // One random cycle against the scoreboard: the queue holds every word the PC
  // has advanced past that decode has not yet taken, oldest first.
  task automatic rand_cycle(input bit quiet);
    bit          exp_ren;
    bit          exp_pcen;
    logic [31:0] tgt;
    ent_t        e;
    @(negedge CLK);
    ihit     = quiet ? 1'b0 : ($urandom_range(0, 3) != 0);
    id_stall = quiet ? 1'b0 : ($urandom_range(0, 2) == 0);
    flush    = quiet ? 1'b0 : ($urandom_range(0, 15) == 0);
    pc_in    = pc_r;
    imemload = ihit ? word(pc_r) : $urandom;
    #1;
    exp_ren  = (q.size() < 2);
    exp_pcen = flush || (exp_ren && ihit);
    chk("rnd imemaddr", imemaddr, pc_in);
    chk("rnd if_npc", if_npc, if_pc + 32'd4);
    chk("rnd if_valid", {31'd0, if_valid}, {31'd0, q.size() != 0});
    chk("rnd imemREN", {31'd0, imemREN}, {31'd0, exp_ren});
    chk("rnd pc_en", {31'd0, pc_en}, {31'd0, exp_pcen});
    if (!flush && if_valid && !id_stall && q.size() != 0) begin
      e = q.pop_front();
      chk("rnd decode pc", if_pc, e.pc);
      chk("rnd decode instr", if_instr, e.ins);
    end
    if (flush) begin
      q.delete();
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      pc_r = tgt;
    end else if (exp_pcen) begin
      e.pc = pc_in;
      e.ins = word(pc_in);
      q.push_back(e);
      pc_r = pc_r + 32'd4;
    end
    @(posedge CLK);
  endtask

  initial begin
    //        pc            hit ld            st fl pcen ren vld ins           pc
    tv[0]  = '{32'h0000_0000, 1, 32'h2001_0000, 0, 0, 1, 1, 1, 32'h2001_0000, 32'h0000_0000};
    tv[1]  = '{32'h0000_0004, 1, 32'h2002_0004, 0, 0, 1, 1, 1, 32'h2002_0004, 32'h0000_0004};
    tv[2]  = '{32'h0000_0008, 1, 32'h2003_0008, 0, 0, 1, 1, 1, 32'h2003_0008, 32'h0000_0008};
    tv[3]  = '{32'h0000_000C, 0, 32'h0000_0000, 0, 0, 0, 1, 0, 32'h2003_0008, 32'h0000_0008};
    tv[4]  = '{32'h0000_0010, 1, 32'h8C00_0010, 0, 0, 1, 1, 1, 32'h8C00_0010, 32'h0000_0010};
    tv[5]  = '{32'h0000_0014, 1, 32'h8C01_0004, 1, 0, 1, 1, 1, 32'h8C00_0010, 32'h0000_0010};
    tv[6]  = '{32'h0000_0018, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 1, 32'h8C00_0010, 32'h0000_0010};
    tv[7]  = '{32'h0000_0018, 0, 32'h0000_0000, 0, 0, 0, 0, 1, 32'h8C01_0004, 32'h0000_0014};
    tv[8]  = '{32'h0000_0018, 0, 32'h0000_0000, 1, 0, 0, 1, 1, 32'h8C01_0004, 32'h0000_0014};
    tv[9]  = '{32'h0000_0018, 1, 32'h8C02_0008, 0, 0, 1, 1, 1, 32'h8C02_0008, 32'h0000_0018};
    tv[10] = '{32'h0000_001C, 1, 32'h1111_1111, 0, 1, 1, 1, 0, 32'h8C02_0008, 32'h0000_0018};
    tv[11] = '{32'h0000_0040, 1, 32'h2222_2222, 1, 0, 1, 1, 1, 32'h2222_2222, 32'h0000_0040};
    tv[12] = '{32'h0000_0044, 1, 32'h3333_3333, 1, 0, 1, 1, 1, 32'h2222_2222, 32'h0000_0040};
    tv[13] = '{32'h0000_0048, 1, 32'h4444_4444, 1, 1, 1, 0, 0, 32'h2222_2222, 32'h0000_0040};
    tv[14] = '{32'h0000_0080, 0, 32'h0000_0000, 0, 0, 0, 1, 0, 32'h2222_2222, 32'h0000_0040};
    tv[15] = '{32'hFFFF_FFFC, 1, 32'h0123_4567, 0, 0, 1, 1, 1, 32'h0123_4567, 32'hFFFF_FFFC};
    tv[16] = '{32'h0000_0000, 0, 32'h0000_0000, 0, 0, 0, 1, 0, 32'h0123_4567, 32'hFFFF_FFFC};

    do_reset();
    #1;
    chk("reset if_valid", {31'd0, if_valid}, 32'd0);
    chk("reset if_instr", if_instr, 32'd0);
    chk("reset if_pc", if_pc, 32'd0);
    chk("reset if_npc", if_npc, 32'd4);
    chk("reset imemREN", {31'd0, imemREN}, 32'd1);
    chk("reset pc_en", {31'd0, pc_en}, 32'd0);

    for (int i = 0; i < 17; i++) begin
      drive(tv[i].pc, tv[i].hit, tv[i].ld, tv[i].st, tv[i].fl);
      chk($sformatf("vec%0d pc_en", i), {31'd0, pc_en}, {31'd0, tv[i].e_pcen});
      chk($sformatf("vec%0d imemREN", i), {31'd0, imemREN}, {31'd0, tv[i].e_ren});
      chk($sformatf("vec%0d imemaddr", i), imemaddr, tv[i].pc);
      tick();
      chk($sformatf("vec%0d if_valid", i), {31'd0, if_valid}, {31'd0, tv[i].e_vld});
      chk($sformatf("vec%0d if_instr", i), if_instr, tv[i].e_ins);
      chk($sformatf("vec%0d if_pc", i), if_pc, tv[i].e_pc);
      chk($sformatf("vec%0d if_npc", i), if_npc, tv[i].e_pc + 32'd4);
    end
    drive(32'h0, 0, 32'h0, 1, 0);
    chk("wrap if_npc", if_npc, 32'd0);

    // HALT captured straight into the output register
    do_reset();
    drive(32'h100, 1, 32'hFFFF_FFFF, 0, 0);
    chk("halt capture pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    chk("halt if_valid", {31'd0, if_valid}, 32'd1);
    chk("halt if_instr", if_instr, 32'hFFFF_FFFF);
    drive(32'h104, 1, 32'h1, 1, 0);
    chk("halted imemREN", {31'd0, imemREN}, 32'd0);
    chk("halted pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    chk("halted hold valid", {31'd0, if_valid}, 32'd1);
    drive(32'h104, 1, 32'h1, 1, 1);
    chk("halted flush pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    chk("halted flush valid", {31'd0, if_valid}, 32'd1);
    chk("halted flush instr", if_instr, 32'hFFFF_FFFF);
    drive(32'h104, 1, 32'h1, 0, 0);
    tick();
    chk("halted drain valid", {31'd0, if_valid}, 32'd0);
    drive(32'h104, 1, 32'h1, 0, 1);
    chk("halted late imemREN", {31'd0, imemREN}, 32'd0);
    chk("halted late pc_en", {31'd0, pc_en}, 32'd0);
    tick();

    // HALT captured into the skid under stall
    do_reset();
    drive(32'h200, 1, 32'h2000_0200, 0, 0);
    tick();
    drive(32'h204, 1, 32'hFFFF_FFFF, 1, 0);
    chk("skid halt pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    chk("skid halt keep pc", if_pc, 32'h200);
    drive(32'h208, 1, 32'h5, 1, 0);
    chk("skid halt hold imemREN", {31'd0, imemREN}, 32'd0);
    chk("skid halt hold pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    drive(32'h208, 1, 32'h5, 0, 0);
    tick();
    chk("skid halt drain instr", if_instr, 32'hFFFF_FFFF);
    chk("skid halt drain pc", if_pc, 32'h204);
    chk("skid halt drain valid", {31'd0, if_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(32'h208, 1, 32'h5, 0, k == 2);
      chk($sformatf("skid halt after%0d imemREN", k), {31'd0, imemREN}, 32'd0);
      chk($sformatf("skid halt after%0d pc_en", k), {31'd0, pc_en}, 32'd0);
      tick();
    end

    // Reset asserted while holding a skid entry
    do_reset();
    drive(32'h300, 1, 32'h0000_AAAA, 0, 0);
    tick();
    drive(32'h304, 1, 32'h0000_BBBB, 1, 0);
    tick();
    drive(32'h308, 0, 32'h0, 1, 0);
    chk("midhold imemREN", {31'd0, imemREN}, 32'd0);
    nRST = 1'b0;
    #1;
    chk("midreset if_valid", {31'd0, if_valid}, 32'd0);
    chk("midreset if_instr", if_instr, 32'd0);
    chk("midreset if_pc", if_pc, 32'd0);
    chk("midreset if_npc", if_npc, 32'd4);
    chk("midreset imemREN", {31'd0, imemREN}, 32'd1);
    chk("midreset pc_en", {31'd0, pc_en}, 32'd0);

    // Randomized run against the queue scoreboard
    do_reset();
    q.delete();
    pc_r = 32'd0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b0);
    for (int c = 0; c < 5; c++) rand_cycle(1'b1);
    chk("rnd no loss", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
